// File: rtl/dec_fpr_pkg.sv
// Shared FPR writeback definitions: register-file geometry and the
// bank-switch sequencer state encoding.
package dec_fpr_pkg;

  localparam int FPR_ADDR_W = 5;
  localparam int FPR_DATA_W = 64;
  localparam int NPORTS     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2
  } fpr_bsw_state_e;

endpackage

// File: rtl/dec_fpr_wb_arb_if.sv
// Writeback request bus between the FPR result producers and the
// writeback arbiter: one valid/addr/data lane per requester, ready back.
interface dec_fpr_wb_arb_if
  import dec_fpr_pkg::*;
#(
  parameter int NREQ = 5
) ();

  logic [NREQ-1:0]                 req_valid;
  logic [NREQ-1:0][FPR_ADDR_W-1:0] req_addr;
  logic [NREQ-1:0][FPR_DATA_W-1:0] req_data;
  logic [NREQ-1:0]                 req_ready;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready
  );

endinterface

// File: rtl/dec_fpr_rr_pick.sv
// Rotate-and-pick-three: scans requesters from ptr, granting up to three
// valid requests while skipping any whose address is already taken this cycle.
module dec_fpr_rr_pick
  import dec_fpr_pkg::*;
#(
  parameter int NREQ  = 5,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]                 valid,
  input  logic [NREQ-1:0][FPR_ADDR_W-1:0] addr,
  input  logic [IDX_W-1:0]                ptr,
  output logic [NREQ-1:0]                 grant,
  output logic [NPORTS-1:0]               port_vld,
  output logic [NPORTS-1:0][IDX_W-1:0]    port_idx
);

  always_comb begin
    logic [1:0]                        n;
    logic [IDX_W:0]                    pos;
    logic [IDX_W-1:0]                  idx;
    logic                              conflict;
    logic [NPORTS-1:0][FPR_ADDR_W-1:0] port_addr;

    grant     = '0;
    port_vld  = '0;
    port_idx  = '0;
    port_addr = '0;
    n         = 2'd0;
    pos       = '0;
    idx       = '0;
    conflict  = 1'b0;

    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(NREQ)) pos = pos - (IDX_W+1)'(NREQ);
      idx = pos[IDX_W-1:0];

      // Two ports must never target the same register in one cycle.
      conflict = 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        if (port_vld[p] && (port_addr[p] == addr[idx])) conflict = 1'b1;
      end

      if (valid[idx] && !conflict && (n != 2'(NPORTS))) begin
        grant[idx]   = 1'b1;
        port_vld[n]  = 1'b1;
        port_idx[n]  = idx;
        port_addr[n] = addr[idx];
        n            = n + 2'd1;
      end
    end
  end

endmodule

// File: rtl/dec_fpr_wb_arb.sv
// FPR writeback arbiter: grants up to three conflict-free results per cycle
// onto registered write ports and sequences bank-ID switches around traffic.
module dec_fpr_wb_arb
  import dec_fpr_pkg::*;
#(
  parameter int NREQ           = 5,
  parameter int GPR_BANKS      = 1,
  parameter int GPR_BANKS_LOG2 = 1
) (
  input  logic                      clk,
  input  logic                      rst_l,
  dec_fpr_wb_arb_if.slave           rq,
  input  logic                      bank_sw_req,
  input  logic [GPR_BANKS_LOG2-1:0] bank_sw_id,
  output logic                      bank_sw_ack,
  output logic                      wen0,
  output logic                      wen1,
  output logic                      wen2,
  output logic [FPR_ADDR_W-1:0]     waddr0,
  output logic [FPR_ADDR_W-1:0]     waddr1,
  output logic [FPR_ADDR_W-1:0]     waddr2,
  output logic [FPR_DATA_W-1:0]     wd0,
  output logic [FPR_DATA_W-1:0]     wd1,
  output logic [FPR_DATA_W-1:0]     wd2,
  output logic                      wen_bank_id,
  output logic [GPR_BANKS_LOG2-1:0] wr_bank_id,
  output logic                      wb_busy
);

  localparam int IDX_W = $clog2(NREQ);

  if ((NREQ < 3) || (NREQ > 8)) begin : g_nreq_chk
    $error("dec_fpr_wb_arb: NREQ must be within 3..8");
  end
  if (GPR_BANKS > (1 << GPR_BANKS_LOG2)) begin : g_bank_chk
    $error("dec_fpr_wb_arb: GPR_BANKS_LOG2 too narrow for GPR_BANKS");
  end

  fpr_bsw_state_e                    state_q;
  logic                              bank_sw_ack_q;
  logic                              wen_bank_id_q;
  logic [GPR_BANKS_LOG2-1:0]         wr_bank_id_q;

  logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NPORTS-1:0]                 wen_q, wen_d;
  logic [NPORTS-1:0][FPR_ADDR_W-1:0] waddr_q, waddr_d;
  logic [NPORTS-1:0][FPR_DATA_W-1:0] wd_q, wd_d;

  logic                              grant_en;
  logic [NREQ-1:0]                   pick_valid;
  logic [NREQ-1:0]                   grant;
  logic [NPORTS-1:0]                 port_vld;
  logic [NPORTS-1:0][IDX_W-1:0]      port_idx;

  // A pending switch request blocks grants in the very cycle it is seen.
  assign grant_en   = (state_q == ST_IDLE) && !bank_sw_req;
  assign pick_valid = rq.req_valid & {NREQ{grant_en}};

  dec_fpr_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid    (pick_valid),
    .addr     (rq.req_addr),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .port_vld (port_vld),
    .port_idx (port_idx)
  );

  assign rq.req_ready = grant;

  always_comb begin
    logic [IDX_W-1:0] last;
    logic [IDX_W:0]   nxt;

    last = port_vld[2] ? port_idx[2] : (port_vld[1] ? port_idx[1] : port_idx[0]);
    nxt  = {1'b0, last} + (IDX_W+1)'(1);
    if (nxt == (IDX_W+1)'(NREQ)) nxt = '0;
    rr_ptr_d = (|port_vld) ? nxt[IDX_W-1:0] : rr_ptr_q;

    for (int p = 0; p < NPORTS; p++) begin
      wen_d[p]   = port_vld[p];
      waddr_d[p] = port_vld[p] ? rq.req_addr[port_idx[p]] : waddr_q[p];
      wd_d[p]    = port_vld[p] ? rq.req_data[port_idx[p]] : wd_q[p];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      rr_ptr_q <= '0;
      wen_q    <= '0;
      waddr_q  <= '0;
      wd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wd_q     <= wd_d;
    end
  end

  // Bank-ID flops only update once every write port has gone quiet.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= ST_IDLE;
      bank_sw_ack_q <= 1'b0;
      wen_bank_id_q <= 1'b0;
      wr_bank_id_q  <= '0;
    end else begin
      bank_sw_ack_q <= 1'b0;
      wen_bank_id_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bank_sw_req) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (wen_q == '0) begin
            state_q       <= ST_SWITCH;
            bank_sw_ack_q <= 1'b1;
            wen_bank_id_q <= 1'b1;
            wr_bank_id_q  <= bank_sw_id;
          end
        end
        ST_SWITCH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign wen0        = wen_q[0];
  assign wen1        = wen_q[1];
  assign wen2        = wen_q[2];
  assign waddr0      = waddr_q[0];
  assign waddr1      = waddr_q[1];
  assign waddr2      = waddr_q[2];
  assign wd0         = wd_q[0];
  assign wd1         = wd_q[1];
  assign wd2         = wd_q[2];
  assign bank_sw_ack = bank_sw_ack_q;
  assign wen_bank_id = wen_bank_id_q;
  assign wr_bank_id  = wr_bank_id_q;
  assign wb_busy     = (|rq.req_valid) | (|wen_q);

endmodule

// File: tb/tb_dec_fpr_wb_arb.sv
// Bench for dec_fpr_wb_arb: directed scenarios plus randomized traffic
// against a queue-based round-robin reference model.
module tb_dec_fpr_wb_arb;

  localparam int NREQ = 5;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        bank_sw_req, bank_sw_id, bank_sw_ack;
  logic        wen0, wen1, wen2, wen_bank_id, wr_bank_id, wb_busy;
  logic [4:0]  waddr0, waddr1, waddr2;
  logic [63:0] wd0, wd1, wd2;

  int n_checks = 0;
  int n_pass   = 0;

  dec_fpr_wb_arb_if #(.NREQ(NREQ)) bus ();

  dec_fpr_wb_arb #(.NREQ(NREQ), .GPR_BANKS(1), .GPR_BANKS_LOG2(1)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .rq          (bus),
    .bank_sw_req (bank_sw_req),
    .bank_sw_id  (bank_sw_id),
    .bank_sw_ack (bank_sw_ack),
    .wen0        (wen0),
    .wen1        (wen1),
    .wen2        (wen2),
    .waddr0      (waddr0),
    .waddr1      (waddr1),
    .waddr2      (waddr2),
    .wd0         (wd0),
    .wd1         (wd1),
    .wd2         (wd2),
    .wen_bank_id (wen_bank_id),
    .wr_bank_id  (wr_bank_id),
    .wb_busy     (wb_busy)
  );

  always #5 clk = ~clk;

  logic [2:0]       wen_v;
  logic [2:0][4:0]  waddr_v;
  logic [2:0][63:0] wd_v;
  assign wen_v   = {wen2, wen1, wen0};
  assign waddr_v = {waddr2, waddr1, waddr0};
  assign wd_v    = {wd2, wd1, wd0};

  // Reference: walk requesters in rotated order, take the first three valid
  // ones whose address has not been taken yet.
  function automatic void model_pick(input logic [NREQ-1:0] v, input logic [NREQ-1:0][4:0] a,
                                     input int ptr, output logic [NREQ-1:0] g,
                                     output int pidx[3], output int np);
    logic [4:0] taken[$];
    g = '0; np = 0; pidx = '{0, 0, 0};
    for (int k = 0; k < NREQ; k++) begin
      int i;
      bit dup;
      i = (ptr + k) % NREQ;
      dup = 0;
      foreach (taken[t]) if (taken[t] == a[i]) dup = 1;
      if (v[i] && !dup && np < 3) begin
        g[i] = 1'b1; pidx[np] = i; np++; taken.push_back(a[i]);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_l = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    bank_sw_req = 1'b0; bank_sw_id = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_l = 1'b1;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    bank_sw_req = 1'b0; bank_sw_id = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b000) $display("FAIL reset_wen: got %b want 000", wen_v); else n_pass++;
    n_checks++; if (waddr_v !== '0) $display("FAIL reset_waddr: got %h want 0", waddr_v); else n_pass++;
    n_checks++; if (wd_v !== '0) $display("FAIL reset_wd: got %h want 0", wd_v); else n_pass++;
    n_checks++; if ({bank_sw_ack, wen_bank_id, wr_bank_id} !== 3'b000)
      $display("FAIL reset_bank: got %b want 000", {bank_sw_ack, wen_bank_id, wr_bank_id}); else n_pass++;
    n_checks++; if (wb_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", wb_busy); else n_pass++;
    @(posedge clk); #1 rst_l = 1'b1;
  endtask

  task automatic test_single();
    logic [63:0] d, da, db;
    d = 64'h3FF0_0000_0000_0000; da = {$urandom, $urandom}; db = {$urandom, $urandom};
    do_reset();
    bus.req_valid = 5'b00100; bus.req_addr[2] = 5'd7; bus.req_data[2] = d;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00100) $display("FAIL single_ready: got %b want 00100", bus.req_ready); else n_pass++;
    n_checks++; if (wb_busy !== 1'b1) $display("FAIL single_busy: got %b want 1", wb_busy); else n_pass++;
    tick();
    bus.req_valid = 5'b01001;
    bus.req_addr[0] = 5'd20; bus.req_data[0] = da;
    bus.req_addr[3] = 5'd21; bus.req_data[3] = db;
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b001) $display("FAIL single_wen: got %b want 001", wen_v); else n_pass++;
    n_checks++; if (waddr0 !== 5'd7) $display("FAIL single_waddr0: got %0d want 7", waddr0); else n_pass++;
    n_checks++; if (wd0 !== d) $display("FAIL single_wd0: got %h want %h", wd0, d); else n_pass++;
    n_checks++; if (bus.req_ready !== 5'b01001) $display("FAIL single_ready2: got %b want 01001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    // rr_ptr is 3 after granting r2, so r3 lands on port 0 ahead of r0
    n_checks++; if (wen_v !== 3'b011) $display("FAIL single_wen2: got %b want 011", wen_v); else n_pass++;
    n_checks++; if ({waddr1, waddr0} !== {5'd20, 5'd21})
      $display("FAIL single_ptr_order: got %0d,%0d want 21,20", waddr0, waddr1); else n_pass++;
    n_checks++; if (wd0 !== db) $display("FAIL single_wd_r3: got %h want %h", wd0, db); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b000 || waddr0 !== 5'd21)
      $display("FAIL single_hold: got wen %b waddr0 %0d want 000/21", wen_v, waddr0); else n_pass++;
  endtask

  task automatic test_five();
    logic [63:0] dat[5];
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      dat[i] = {$urandom, $urandom};
      bus.req_addr[i] = 5'(i + 1); bus.req_data[i] = dat[i];
    end
    bus.req_valid = 5'b11111;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00111) $display("FAIL five_ready0: got %b want 00111", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 5'b11000;
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b111) $display("FAIL five_wen0: got %b want 111", wen_v); else n_pass++;
    n_checks++; if (waddr_v !== {5'd3, 5'd2, 5'd1}) $display("FAIL five_waddr0: got %h want 3/2/1", waddr_v); else n_pass++;
    n_checks++; if (wd2 !== dat[2]) $display("FAIL five_wd2: got %h want %h", wd2, dat[2]); else n_pass++;
    n_checks++; if (bus.req_ready !== 5'b11000) $display("FAIL five_ready1: got %b want 11000", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 5'b10001;
    bus.req_addr[0] = 5'd17; bus.req_addr[4] = 5'd18;
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b011) $display("FAIL five_wen1: got %b want 011", wen_v); else n_pass++;
    n_checks++; if (waddr_v !== {5'd3, 5'd5, 5'd4}) $display("FAIL five_waddr1: got %h want 3/5/4", waddr_v); else n_pass++;
    n_checks++; if (wd1 !== dat[4]) $display("FAIL five_wd1: got %h want %h", wd1, dat[4]); else n_pass++;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++; if ({waddr1, waddr0} !== {5'd18, 5'd17})
      $display("FAIL five_ptr_wrap: got %0d,%0d want 17,18", waddr0, waddr1); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [63:0] dat[3];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dat[i] = {$urandom, $urandom}; bus.req_data[i] = dat[i];
    end
    bus.req_addr[0] = 5'd9; bus.req_addr[1] = 5'd9; bus.req_addr[2] = 5'd4;
    bus.req_valid = 5'b00111;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00101) $display("FAIL conf_ready0: got %b want 00101", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 5'b00010;
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b011 || waddr0 !== 5'd9 || waddr1 !== 5'd4)
      $display("FAIL conf_ports0: got wen %b a0 %0d a1 %0d want 011/9/4", wen_v, waddr0, waddr1); else n_pass++;
    n_checks++; if (wd0 !== dat[0]) $display("FAIL conf_wd0: got %h want %h", wd0, dat[0]); else n_pass++;
    n_checks++; if (bus.req_ready !== 5'b00010) $display("FAIL conf_ready1: got %b want 00010", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b001 || waddr0 !== 5'd9 || wd0 !== dat[1])
      $display("FAIL conf_r1: got wen %b a0 %0d d0 %h want 001/9/%h", wen_v, waddr0, wd0, dat[1]); else n_pass++;
  endtask

  task automatic test_bank_switch();
    do_reset();
    bus.req_valid = 5'b00001; bus.req_addr[0] = 5'd3;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00001) $display("FAIL bsw_ready_c0: got %b want 00001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 5'b00010; bus.req_addr[1] = 5'd6; bank_sw_req = 1'b1; bank_sw_id = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00000 || wen0 !== 1'b1 || bank_sw_ack !== 1'b0)
      $display("FAIL bsw_c1: got rdy %b wen0 %b ack %b want 00000/1/0", bus.req_ready, wen0, bank_sw_ack); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00000 || wen_v !== 3'b000 || bank_sw_ack !== 1'b0)
      $display("FAIL bsw_c2: got rdy %b wen %b ack %b want 00000/000/0", bus.req_ready, wen_v, bank_sw_ack); else n_pass++;
    tick();
    @(negedge clk);
    n_checks++; if ({bank_sw_ack, wen_bank_id, wr_bank_id} !== 3'b111)
      $display("FAIL bsw_c3_ack: got %b want 111", {bank_sw_ack, wen_bank_id, wr_bank_id}); else n_pass++;
    n_checks++; if (bus.req_ready !== 5'b00000) $display("FAIL bsw_c3_ready: got %b want 00000", bus.req_ready); else n_pass++;
    tick();
    bank_sw_req = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00010 || bank_sw_ack !== 1'b0 || wen_bank_id !== 1'b0)
      $display("FAIL bsw_c4: got rdy %b ack %b wbid %b want 00010/0/0", bus.req_ready, bank_sw_ack, wen_bank_id); else n_pass++;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd6)
      $display("FAIL bsw_c5: got wen0 %b a0 %0d want 1/6", wen0, waddr0); else n_pass++;
    bank_sw_id = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] dx, dy;
    dx = {$urandom, $urandom}; dy = {$urandom, $urandom};
    do_reset();
    bus.req_valid = 5'b00001; bus.req_addr[0] = 5'd11; bus.req_data[0] = dx;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00001) $display("FAIL rmid_ready0: got %b want 00001", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = 5'b00100; bus.req_addr[2] = 5'd12; bus.req_data[2] = dy; bank_sw_req = 1'b1;
    @(negedge clk);
    n_checks++; if (wen0 !== 1'b1 || waddr0 !== 5'd11) $display("FAIL rmid_pre: got wen0 %b a0 %0d want 1/11", wen0, waddr0); else n_pass++;
    #2 rst_l = 1'b0;
    #1;
    n_checks++; if (wen_v !== 3'b000 || waddr_v !== '0 || wd_v !== '0)
      $display("FAIL rmid_async_ports: got wen %b a %h d0 %h want all 0", wen_v, waddr_v, wd0); else n_pass++;
    n_checks++; if ({bank_sw_ack, wen_bank_id, wr_bank_id} !== 3'b000)
      $display("FAIL rmid_async_bank: got %b want 000", {bank_sw_ack, wen_bank_id, wr_bank_id}); else n_pass++;
    @(posedge clk); #1;
    bank_sw_req = 1'b0;
    bus.req_valid = 5'b00101; bus.req_addr[0] = 5'd13;
    rst_l = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 5'b00101) $display("FAIL rmid_first_grant: got %b want 00101", bus.req_ready); else n_pass++;
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    n_checks++; if (wen_v !== 3'b011 || waddr0 !== 5'd13 || waddr1 !== 5'd12 || wd1 !== dy)
      $display("FAIL rmid_after: got wen %b a0 %0d a1 %0d d1 %h want 011/13/12/%h", wen_v, waddr0, waddr1, wd1, dy); else n_pass++;
  endtask

  task automatic test_fairness();
    int waitc[NREQ];
    int maxw[NREQ];
    logic [NREQ-1:0] g;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      waitc[i] = 0; maxw[i] = 0;
      bus.req_addr[i] = 5'(i + 1); bus.req_data[i] = {$urandom, $urandom};
    end
    bus.req_valid = 5'b10111;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      g = bus.req_ready;
      for (int i = 0; i < NREQ; i++) begin
        if (g[i]) waitc[i] = 0;
        else waitc[i]++;
        if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
      end
      tick();
      for (int i = 0; i < NREQ; i++) if (g[i]) bus.req_data[i] = {$urandom, $urandom};
    end
    foreach (maxw[i]) begin
      if (i != 3) begin
        n_checks++; if (maxw[i] > 2) $display("FAIL fair_r%0d: got max wait %0d want <=2", i, maxw[i]); else n_pass++;
      end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_random(input int ncyc);
    logic [NREQ-1:0]  g;
    int               pidx[3];
    int               np;
    logic [2:0]       m_wen;
    logic [2:0][4:0]  m_waddr;
    logic [2:0][63:0] m_wd;
    int               m_ptr, m_mode;
    logic             m_bid;
    bit               ack_now;
    do_reset();
    m_wen = '0; m_waddr = '0; m_wd = '0; m_ptr = 0; m_mode = 0; m_bid = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (m_mode == 0 && !bank_sw_req) model_pick(bus.req_valid, bus.req_addr, m_ptr, g, pidx, np);
      else begin g = '0; np = 0; end
      n_checks++; if (bus.req_ready !== g) $display("FAIL rand_ready c%0d: got %b want %b", c, bus.req_ready, g); else n_pass++;
      n_checks++; if (wen_v !== m_wen) $display("FAIL rand_wen c%0d: got %b want %b", c, wen_v, m_wen); else n_pass++;
      n_checks++; if (waddr_v !== m_waddr) $display("FAIL rand_waddr c%0d: got %h want %h", c, waddr_v, m_waddr); else n_pass++;
      n_checks++; if (wd_v !== m_wd) $display("FAIL rand_wd c%0d: got %h want %h", c, wd_v, m_wd); else n_pass++;
      n_checks++; if ({bank_sw_ack, wen_bank_id} !== {2{m_mode == 2}})
        $display("FAIL rand_ack c%0d: got %b want %b", c, {bank_sw_ack, wen_bank_id}, {2{m_mode == 2}}); else n_pass++;
      if (m_mode == 2) begin
        n_checks++; if (wr_bank_id !== m_bid) $display("FAIL rand_bank_id c%0d: got %b want %b", c, wr_bank_id, m_bid); else n_pass++;
      end
      n_checks++; if (wb_busy !== ((|bus.req_valid) || (|m_wen)))
        $display("FAIL rand_busy c%0d: got %b want %b", c, wb_busy, ((|bus.req_valid) || (|m_wen))); else n_pass++;

      ack_now = (m_mode == 2);
      case (m_mode)
        0: if (bank_sw_req) m_mode = 1;
        1: if (m_wen == 3'b000) begin m_mode = 2; m_bid = bank_sw_id; end
        default: m_mode = 0;
      endcase
      m_wen = '0;
      for (int p = 0; p < np; p++) begin
        m_wen[p] = 1'b1; m_waddr[p] = bus.req_addr[pidx[p]]; m_wd[p] = bus.req_data[pidx[p]];
      end
      if (np > 0) m_ptr = (pidx[np-1] + 1) % NREQ;

      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (g[i] || !bus.req_valid[i]) begin
          bus.req_valid[i] = ($urandom_range(0, 2) != 0);
          bus.req_addr[i]  = 5'($urandom_range(0, 7));
          bus.req_data[i]  = {$urandom, $urandom};
        end
      end
      if (ack_now) bank_sw_req = 1'b0;
      else if (!bank_sw_req && $urandom_range(0, 19) == 0) begin
        bank_sw_req = 1'b1; bank_sw_id = 1'($urandom_range(0, 1));
      end
    end
    bus.req_valid = '0; bank_sw_req = 1'b0;
    tick();
  endtask

  initial begin
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
    bank_sw_req = 1'b0; bank_sw_id = 1'b0;
    test_reset();
    test_single();
    test_five();
    test_conflict();
    test_bank_switch();
    test_reset_mid();
    test_fairness();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
